regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the single register-file access port (write command, file address, write data, read data)
//  between the core execute stage and a debug/host requester.
//  The core owns the port by default. A debug access is granted for exactly one cycle, during which
//  the core is stalled. A starvation counter guarantees debug progress under continuous core traffic.
//  Sits between the execute/control unit and the register file.
// PARAMETERS
//  DATA_WIDTH    8  register/data width
//  ADDR_WIDTH    5  file address width
//  STARVE_LIMIT  4  conflict cycles tolerated before debug is forced in (>=1)
// PORTS
//  clk           in   1           clock; all state updates on rising edge
//  rst           in   1           asynchronous reset, active low
//  core_valid    in   1           core uses the port this cycle (read or write)
//  core_wr_cmd   in   3           core write command (0=none, 001 status, 010 file, 011 file+status)
//  core_addr     in   ADDR_WIDTH  core file address
//  core_wdata    in   DATA_WIDTH  core write data
//  core_stall    out  1           core access this cycle not performed; core holds its state
//  dbg_req       in   1           debug request, level, 4-phase
//  dbg_we        in   1           1=write, 0=read; sampled at grant
//  dbg_addr      in   ADDR_WIDTH  debug file address; sampled at grant
//  dbg_wdata     in   DATA_WIDTH  debug write data; sampled at grant
//  dbg_ack       out  1           access complete; held until dbg_req low
//  dbg_rdata     out  DATA_WIDTH  read result; valid while dbg_ack=1
//  dbg_err       out  1           write rejected; valid while dbg_ack=1
//  rf_write_cmd  out  3           to register file write command
//  rf_file_addr  out  ADDR_WIDTH  to register file address
//  rf_wdata      out  DATA_WIDTH  to register file write data
//  rf_rdata      in   DATA_WIDTH  from register file read data (combinational read)
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; starve_cnt=0; dbg_ack=0; dbg_rdata=0; dbg_err=0; core_stall=0.
//   An in-flight access is abandoned: no ack and no write.
//  FSM IDLE -> ACC -> DONE -> IDLE.
//  IDLE:
//   - rf_* = core_wr_cmd / core_addr / core_wdata (pass-through); core_stall=0.
//   - grant = dbg_req & (!core_valid | starve_cnt==STARVE_LIMIT).
//   - On grant: latch dbg_we, dbg_addr, dbg_wdata; starve_cnt<=0; go to ACC.
//   - Else if dbg_req & core_valid: starve_cnt<=starve_cnt+1 (saturates at STARVE_LIMIT).
//   - Else if !dbg_req: starve_cnt<=0.
//  ACC (exactly 1 cycle):
//   - core_stall=1; rf_file_addr=latched addr.
//   - rf_write_cmd=3'b010 if latched we and addr not protected, else 3'b000; rf_wdata=latched data.
//   - At the end-of-cycle edge: dbg_rdata<=rf_rdata on reads (unchanged on writes).
//   - dbg_err<=1 if a write targets protected addr 0x01 (TMR0) or 0x02 (PCL), else 0.
//   - Go to DONE with dbg_ack<=1.
//  DONE:
//   - rf_* pass-through from the core again; core_stall=0.
//   - dbg_ack, dbg_rdata and dbg_err hold.
//   - When dbg_req=0: dbg_ack<=0, go to IDLE.
//   - dbg_req is not re-sampled for a new grant until back in IDLE.
//  Latency (core idle): dbg_req high in cycle N -> ACC in N+1 -> dbg_ack high from N+2.
//  Debug never drives status writes (001/011).
//  Indirect address 0x00 is allowed and resolves through FSR in the register file.
//  Read data is captured combinationally from the same cycle as ACC, so debug reads have no extra
//   wait state.
//  Core writes are never dropped: a stalled core re-presents the same access next cycle.
//  Debug inputs changing after grant have no effect on the access in progress.
// TESTING
//  T1: Core writes 0x5A to 0x08; later dbg read 0x08 with core_valid=0, req in cycle N
//      -> core_stall=1 only in N+1; dbg_ack from N+2; dbg_rdata=0x5A; dbg_err=0.
//  T2: Dbg write 0x3C to 0x10, core idle -> rf_write_cmd=010, addr 0x10, data 0x3C for exactly one
//      cycle; follow-up read returns 0x3C.
//  T3: core_valid held 1, dbg_req rises in cycle 0, STARVE_LIMIT=4 -> core_stall=1 exactly in
//      cycle 5; dbg_ack from cycle 6; core stream otherwise uninterrupted.
//  T4: Dbg write 0xFF to 0x02 -> rf_write_cmd stays 000 throughout; dbg_ack with dbg_err=1;
//      PCL unchanged.
//  T5: dbg_req held 3 cycles after ack -> dbg_ack held; drops the cycle after req falls.
//      Re-raising req while in DONE causes no second grant.
//  T6: rst pulled low mid-ACC (before the edge) -> outputs at reset values immediately; no write;
//      no ack; after release, a fresh request completes normally.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter
// Brief    : Shares the register-file access port between the execute stage
//            and a debug requester; each debug access steals one core cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_valid,
    input  logic [2:0]            core_wr_cmd,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_err,
    output logic [2:0]            rf_write_cmd,
    output logic [ADDR_WIDTH-1:0] rf_file_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CNT_W-1:0]    c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);
    localparam logic [2:0]            c_CMD_NONE   = 3'b000;
    localparam logic [2:0]            c_CMD_FILE   = 3'b010;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_TMR0  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_PCL   = ADDR_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_starveCnt;
    logic [2:0]              r_accCmd;
    logic [ADDR_WIDTH-1:0]   r_accAddr;
    logic [DATA_WIDTH-1:0]   r_accData;
    logic                    r_accRead;
    logic                    r_accErr;
    logic                    r_coreStall;
    logic                    r_dbgAck;
    logic                    r_dbgErr;
    logic [DATA_WIDTH-1:0]   r_dbgRdata;

    logic w_protected;
    logic w_starved;
    logic w_grant;

    assign w_protected = (dbg_addr == c_ADDR_TMR0) || (dbg_addr == c_ADDR_PCL);
    assign w_starved   = (r_starveCnt == c_STARVE_MAX);
    assign w_grant     = dbg_req && (!core_valid || w_starved);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_starveCnt <= '0;
            r_accCmd    <= c_CMD_NONE;
            r_accAddr   <= '0;
            r_accData   <= '0;
            r_accRead   <= 1'b0;
            r_accErr    <= 1'b0;
            r_coreStall <= 1'b0;
            r_dbgAck    <= 1'b0;
            r_dbgErr    <= 1'b0;
            r_dbgRdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        // Write command and error are resolved here so ACC only muxes registers.
                        r_accCmd    <= (dbg_we && !w_protected) ? c_CMD_FILE : c_CMD_NONE;
                        r_accAddr   <= dbg_addr;
                        r_accData   <= dbg_wdata;
                        r_accRead   <= !dbg_we;
                        r_accErr    <= dbg_we && w_protected;
                        r_starveCnt <= '0;
                        r_coreStall <= 1'b1;
                        r_state     <= S_ACC;
                    end else if (dbg_req && core_valid) begin
                        // Not granted implies not yet at the limit, so this cannot overflow.
                        r_starveCnt <= r_starveCnt + 1'b1;
                    end else if (!dbg_req) begin
                        r_starveCnt <= '0;
                    end
                end
                S_ACC: begin
                    if (r_accRead) begin
                        r_dbgRdata <= rf_rdata;
                    end
                    r_dbgErr    <= r_accErr;
                    r_dbgAck    <= 1'b1;
                    r_coreStall <= 1'b0;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (!dbg_req) begin
                        r_dbgAck <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The core owns the port in every state except the single ACC cycle.
    always_comb begin
        rf_write_cmd = core_wr_cmd;
        rf_file_addr = core_addr;
        rf_wdata     = core_wdata;
        if (r_state == S_ACC) begin
            rf_write_cmd = r_accCmd;
            rf_file_addr = r_accAddr;
            rf_wdata     = r_accData;
        end
    end

    assign core_stall = r_coreStall;
    assign dbg_ack    = r_dbgAck;
    assign dbg_rdata  = r_dbgRdata;
    assign dbg_err    = r_dbgErr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_regfile_port_arbiter
// Brief    : Random and directed stimulus for regfile_port_arbiter, checked
//            through an expectation queue and a register-file content model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          core_valid = 1'b0;
    logic [2:0]    core_wr_cmd = 3'b000;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_stall;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_err;
    logic [2:0]    rf_write_cmd;
    logic [AW-1:0] rf_file_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    always #5 clk = ~clk;

    regfile_port_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_valid  (core_valid),
        .core_wr_cmd (core_wr_cmd),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .dbg_err     (dbg_err),
        .rf_write_cmd(rf_write_cmd),
        .rf_file_addr(rf_file_addr),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata)
    );

    function automatic logic [DW-1:0] initVal(input int i);
        return DW'((i * 37 + 11) & 255);
    endfunction

    // Register file attached to the port: combinational read, file write on 010/011.
    logic [DW-1:0] rfMem [32];
    logic          memLoad = 1'b1;
    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= initVal(i);
        end else if (rf_write_cmd[1]) begin
            rfMem[rf_file_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rfMem[rf_file_addr];

    // Core traffic: 0 idle, 1 continuous writes to 0x18-0x1F, 2 random on 0x10-0x1F, 3 write 0x5A to 0x08.
    int            coreMode = 0;
    bit            pend = 1'b0;
    bit            pv = 1'b0;
    int            rot = 0;
    int            rsel;
    logic [2:0]    pCmd = 3'b000;
    logic [AW-1:0] pAddr = '0;
    logic [DW-1:0] pData = '0;
    logic [DW-1:0] coreModel [32];
    bit            coreTouched [32];

    always @(negedge clk) begin
        if (coreMode == 0) begin
            pend        = 1'b0;
            core_valid  = 1'b0;
            core_wr_cmd = 3'b000;
        end else begin
            if (!pend) begin
                case (coreMode)
                    1: begin
                        pv = 1'b1; pCmd = 3'b010; pAddr = AW'(24 + rot % 8); pData = DW'($urandom); rot++;
                    end
                    3: begin
                        pv = 1'b1; pCmd = 3'b010; pAddr = AW'(8); pData = 8'h5A;
                    end
                    default: begin
                        pv    = ($urandom_range(0, 99) < 70);
                        rsel  = int'($urandom_range(0, 2));
                        pCmd  = !pv ? 3'b000 : (rsel == 0) ? 3'b000 : (rsel == 1) ? 3'b010 : 3'b011;
                        pAddr = AW'(16 + $urandom_range(0, 15));
                        pData = DW'($urandom);
                    end
                endcase
                pend = 1'b1;
            end
            core_valid  = pv;
            core_wr_cmd = pCmd;
            core_addr   = pAddr;
            core_wdata  = pData;
            // An access presented in a non-stalled cycle is performed at the next edge.
            if (!core_stall) begin
                if (pCmd[1]) begin
                    coreModel[pAddr]   = pData;
                    coreTouched[pAddr] = 1'b1;
                end
                pend = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          expQ [$];
    exp_t          cur;
    bit            curValid = 1'b0;
    bit            prevAck = 1'b0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] dbgModel [32];
    logic [DW-1:0] lastRd = '0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
        return coreTouched[a] ? coreModel[a] : dbgModel[a];
    endfunction

    // One debug transaction; expStall < 0 means the grant cycle depends on core traffic.
    task automatic dbgRun(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int expStall, input int holdCycles);
        exp_t e;
        logic err;
        int   stallAt, ackAt, nStall;
        err = we && (a == AW'(1) || a == AW'(2));
        if (!we) lastRd = modelRead(a);
        else if (!err) dbgModel[a] = d;
        e.rdata = lastRd;
        e.err   = err;
        expQ.push_back(e);
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        stallAt = -1; ackAt = -1; nStall = 0;
        for (int k = 1; k <= 30 && ackAt < 0; k++) begin
            @(negedge clk);
            if (core_stall) begin
                nStall++;
                if (stallAt < 0) begin
                    stallAt = k;
                    chk("acc_cmd", 32'(rf_write_cmd), (we && !err) ? 32'd2 : 32'd0);
                    chk("acc_addr", 32'(rf_file_addr), 32'(a));
                    if (we) chk("acc_wdata", 32'(rf_wdata), 32'(d));
                    dbg_we = ~we; dbg_addr = AW'($urandom); dbg_wdata = DW'($urandom);
                end
            end
            if (dbg_ack) ackAt = k;
        end
        if (ackAt < 0) begin
            chk("ack_timeout", 32'd0, 32'd1);
            if (expQ.size() > 0) void'(expQ.pop_back());
        end else if (expStall >= 0) begin
            chk("stall_cycle", 32'(stallAt), 32'(expStall));
            chk("ack_cycle", 32'(ackAt), 32'(expStall + 1));
        end else begin
            chk("ack_bound", 32'(ackAt <= SL + 2), 32'd1);
        end
        chk("stall_count", 32'(nStall), 32'd1);
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            chk("ack_hold", 32'(dbg_ack), 32'd1);
            chk("no_regrant", 32'(core_stall), 32'd0);
        end
        dbg_req = 1'b0;
        @(negedge clk);
        chk("ack_drop", 32'(dbg_ack), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rwe;
        logic [AW-1:0] ra;
        for (int i = 0; i < 32; i++) dbgModel[i] = initVal(i);

        fork
            forever begin
                @(negedge clk);
                if (dbg_ack && !prevAck) begin
                    if (expQ.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                        curValid = 1'b0;
                    end else begin
                        cur = expQ.pop_front();
                        curValid = 1'b1;
                        chk("sb_rdata", 32'(dbg_rdata), 32'(cur.rdata));
                        chk("sb_err", 32'(dbg_err), 32'(cur.err));
                    end
                end else if (dbg_ack && curValid) begin
                    chk("sb_hold", {23'd0, dbg_rdata, dbg_err}, {23'd0, cur.rdata, cur.err});
                end
                if (!dbg_ack) curValid = 1'b0;
                if (core_stall) chk("stall_no_status", 32'(rf_write_cmd == 3'b001 || rf_write_cmd == 3'b011), 32'd0);
                prevAck = dbg_ack;
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rdata", 32'(dbg_rdata), 32'd0);
        chk("rst_err", 32'(dbg_err), 32'd0);
        @(negedge clk);
        memLoad = 1'b0;
        rst = 1'b1;

        // Core writes 0x5A to 0x08, then a debug read with the core idle.
        @(posedge clk); coreMode = 3;
        repeat (3) @(posedge clk);
        coreMode = 0;
        repeat (2) @(negedge clk);
        dbgRun(1'b0, AW'(8), '0, 1, 0);

        // Debug write then read-back; protected write; ack held while req stays high.
        dbgRun(1'b1, AW'(16), 8'h3C, 1, 0);
        dbgRun(1'b0, AW'(16), '0, 1, 0);
        dbgRun(1'b1, AW'(2), 8'hFF, 1, 0);
        dbgRun(1'b0, AW'(2), '0, 1, 0);
        dbgRun(1'b1, AW'(1), 8'h77, 1, 1);
        dbgRun(1'b0, AW'(3), '0, 1, 3);
        dbgRun(1'b1, AW'(0), 8'hA5, 1, 0);

        // Continuous core traffic forces the starvation path.
        @(posedge clk); coreMode = 1;
        repeat (3) @(negedge clk);
        dbgRun(1'b0, AW'(9), '0, SL + 1, 0);
        @(posedge clk); coreMode = 0;
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of the ACC cycle of a write.
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = AW'(5); dbg_wdata = ~dbgModel[5];
        @(negedge clk);
        chk("t6_in_acc", 32'(core_stall), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_stall", 32'(core_stall), 32'd0);
        chk("t6_ack", 32'(dbg_ack), 32'd0);
        chk("t6_cmd", 32'(rf_write_cmd), 32'd0);
        chk("t6_rdata", 32'(dbg_rdata), 32'd0);
        dbg_req = 1'b0;
        lastRd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dbgRun(1'b1, AW'(6), 8'h00, 1, 0);
        dbgRun(1'b0, AW'(8), '0, 1, 1);

        // Random phase: core on 0x10-0x1F, debug on 0x00-0x0F.
        @(posedge clk); coreMode = 2;
        for (int n = 0; n < 40; n++) begin
            rwe = 1'(($urandom) & 1);
            ra  = AW'($urandom_range(0, 15));
            if (ra == AW'(8)) rwe = 1'b0;
            dbgRun(rwe, ra, DW'($urandom), -1, int'($urandom_range(0, 2)));
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end
        @(posedge clk); coreMode = 0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("mem[%0d]", i), 32'(rfMem[i]), 32'(modelRead(AW'(i))));
        end
        chk("queue_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
